// File: rtl/pc_unit_if.sv
// Bus bundle between fetch/control (master) and pc_unit (slave).
// No valid/ready pair: an op is consumed on every rising edge unless stall=1.
interface pc_unit_if #(
   parameter int WIDTH       = 16,
   parameter int STACK_DEPTH = 4
);
   localparam int DW = $clog2(STACK_DEPTH + 1);

   logic             stall;
   logic [2:0]       op;
   logic             cond;
   logic [WIDTH-1:0] offset;
   logic [WIDTH-1:0] target;
   logic [WIDTH-1:0] pc;
   logic [WIDTH-1:0] ret_top;
   logic [DW-1:0]    depth;
   logic             stack_full;
   logic             stack_empty;
   logic             err;

   modport master (
      output stall, op, cond, offset, target,
      input  pc, ret_top, depth, stack_full, stack_empty, err
   );

   modport slave (
      input  stall, op, cond, offset, target,
      output pc, ret_top, depth, stack_full, stack_empty, err
   );
endinterface

// File: rtl/pc_unit.sv
// Program counter with branch/jump and an optional return-address stack.
// Define PC_STACK_EN to build the stack; otherwise CALL acts as JMP and RET as INC.
module pc_unit #(
   parameter int               WIDTH       = 16,
   parameter logic [WIDTH-1:0] RESET_ADDR  = '0,
   parameter int               INC         = 1,
   parameter int               STACK_DEPTH = 4
) (
   input  logic     clk,
   input  logic     rst_n,
   pc_unit_if.slave bus
);
   localparam int DW = $clog2(STACK_DEPTH + 1);
   localparam int AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

   localparam logic [2:0] OP_BR   = 3'd1;
   localparam logic [2:0] OP_JMP  = 3'd2;
   localparam logic [2:0] OP_CALL = 3'd3;
`ifdef PC_STACK_EN
   localparam logic [2:0] OP_RET  = 3'd4;
`endif

   logic [WIDTH-1:0] pc_q;
   logic [WIDTH-1:0] pc_inc;

   assign pc_inc = pc_q + WIDTH'(INC);

`ifdef PC_STACK_EN
   logic [WIDTH-1:0] stk_q [STACK_DEPTH];
   logic [DW-1:0]    depth_q;
   logic             err_q;
   logic             full;
   logic             empty;
   logic [AW-1:0]    top_idx;
   logic [AW-1:0]    push_idx;

   assign full     = (depth_q == DW'(STACK_DEPTH));
   assign empty    = (depth_q == '0);
   assign top_idx  = AW'(depth_q - 1'b1);
   assign push_idx = AW'(depth_q);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q <= RESET_ADDR;
`ifdef PC_STACK_EN
         depth_q <= '0;
         err_q   <= 1'b0;
         for (int i = 0; i < STACK_DEPTH; i++) stk_q[i] <= '0;
`endif
      end else if (!bus.stall) begin
         case (bus.op)
            OP_BR:   pc_q <= bus.cond ? (pc_q + bus.offset) : pc_inc;
            OP_JMP:  pc_q <= bus.target;
`ifdef PC_STACK_EN
            OP_CALL: begin
               pc_q <= bus.target;
               if (full) begin
                  err_q <= 1'b1;
               end else begin
                  stk_q[push_idx] <= pc_inc;
                  depth_q         <= depth_q + 1'b1;
               end
            end
            OP_RET: begin
               if (empty) begin
                  pc_q  <= pc_inc;
                  err_q <= 1'b1;
               end else begin
                  // Popped slot is cleared so ret_top stays a plain indexed read.
                  pc_q           <= stk_q[top_idx];
                  stk_q[top_idx] <= '0;
                  depth_q        <= depth_q - 1'b1;
               end
            end
`else
            OP_CALL: pc_q <= bus.target;
`endif
            default: pc_q <= pc_inc;
         endcase
      end
   end

   assign bus.pc = pc_q;

`ifdef PC_STACK_EN
   assign bus.ret_top     = empty ? '0 : stk_q[top_idx];
   assign bus.depth       = depth_q;
   assign bus.stack_full  = full;
   assign bus.stack_empty = empty;
   assign bus.err         = err_q;
`else
   assign bus.ret_top     = '0;
   assign bus.depth       = '0;
   assign bus.stack_full  = 1'b0;
   assign bus.stack_empty = 1'b1;
   assign bus.err         = 1'b0;
`endif
endmodule
